pulse_train_generator: RTL and testbench
========================================

PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL provide parameter LEN_W, default 16: bit width of the high/low phase length inputs and counters.
REQ-002 SHALL provide parameter NUM_W, default 8: bit width of the pulse count input and counter.
REQ-003 SHALL provide ports: clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide trig  input  1: single-cycle start request, sampled on the rising edge of clk.
REQ-005 SHALL provide abort  input  1: stops the train immediately.
REQ-006 SHALL provide high_len  input  LEN_W: high-phase length in cycles, latched on an accepted trig.
REQ-007 SHALL provide low_len  input  LEN_W: low-phase length in cycles, latched on an accepted trig.
REQ-008 SHALL provide num  input  NUM_W: number of pulses, latched on an accepted trig.
REQ-009 SHALL provide pulse_out  output  1: generated waveform, driven directly from a flop.
REQ-010 SHALL provide busy  output  1: high while a train is in progress.
REQ-011 SHALL provide done  output  1: single-cycle pulse when a train completes normally.

Function
REQ-012 SHALL implement the FSM states IDLE, HIGH, LOW and FIN.
REQ-013 IDLE: trig=1 with abort=0 SHALL latch high_len, low_len and num, and move to HIGH; if num=0, it SHALL move to FIN instead.
REQ-014 Latency: trig accepted at edge t SHALL drive pulse_out=1 and busy=1 during cycle t+1.
REQ-015 HIGH SHALL last max(high_len,1) cycles with pulse_out=1; high_len=0 SHALL be treated as 1.
REQ-016 At the end of HIGH, the FSM SHALL go to LOW if pulses remain, otherwise to FIN.
REQ-017 LOW SHALL last max(low_len,1) cycles with pulse_out=0, then go to HIGH.
REQ-018 No LOW phase SHALL follow the last pulse.
REQ-019 FIN SHALL last exactly one cycle with done=1, busy=0 and pulse_out=0, then go to IDLE.
REQ-020 Pulse counter SHALL decrement once per completed HIGH phase; num=2^NUM_W-1 SHALL produce exactly that many pulses, with no wrap.
REQ-021 Phase counters SHALL be down-counters loaded with length-1; the phase SHALL end when the count reaches 0, with no wrap past 0.
REQ-022 trig while busy=1 or in FIN SHALL be ignored, and latched values SHALL be unchanged (unless the REQ-031 macro is defined).
REQ-023 abort=1 in any state SHALL force IDLE on the next edge, with pulse_out=0, busy=0 and no done pulse.
REQ-024 abort and trig in the same cycle: abort SHALL win and the trig SHALL be dropped.
REQ-025 Input changes on high_len, low_len or num during a train SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear state to IDLE and set pulse_out=0, busy=0 and done=0.
REQ-027 rst_n=0 SHALL clear all counters and latched registers to 0.
REQ-028 Reset asserted mid-train SHALL terminate the train, and no done SHALL follow.
REQ-029 After reset release, the first trig SHALL be accepted on the first rising edge.

Configuration
REQ-030 The macro PULSE_TRAIN_RETRIG_EN SHALL control retriggering.
REQ-031 With PULSE_TRAIN_RETRIG_EN defined, trig in HIGH, LOW or FIN SHALL relatch the inputs and restart at HIGH (or FIN if num=0) on the next cycle, and no done SHALL be emitted for the interrupted train.
REQ-032 Without PULSE_TRAIN_RETRIG_EN, behaviour SHALL be exactly REQ-022.

Structure
REQ-033 Package pulse_train_pkg SHALL hold the state enum type (IDLE/HIGH/LOW/FIN) and the default LEN_W/NUM_W constants.
REQ-034 Sub-module pulse_train_cnt SHALL be used for the phase and pulse counters: parameterised-width, loadable down-counter with load, en and zero outputs; one instance each.

Verification
REQ-035 high_len=3, low_len=2, num=3, trig at cycle 0 -> pulse_out 1 in cycles 1-3, 6-8, 11-13; done=1 in cycle 14; busy=1 in cycles 1-13.
REQ-036 num=0, trig -> pulse_out stays 0; busy stays 0; done=1 in the next cycle.
REQ-037 high_len=0, low_len=0, num=4 -> alternating 1/0 train of 4 high cycles over cycles 1-7; done in cycle 8.
REQ-038 abort in the 2nd LOW phase of num=5 -> pulse_out=0 and busy=0 from the next cycle; no done; a new trig is accepted afterwards.
REQ-039 trig repeated in cycle 2 of a train (macro undefined) -> ignored and timing unchanged; with macro defined -> restart, and the first done appears only after the full new train.
REQ-040 rst_n low in the middle of a HIGH phase -> pulse_out=0 immediately (asynchronously); done never asserted.

Source files
------------

// File: rtl/pulse_train_pkg.sv
// ============================================================================
// Module : pulse_train_pkg
// Brief  : Shared state type and default widths for the pulse train generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_train_pkg;

  localparam int LEN_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pulse_train_cnt.sv
// ============================================================================
// Module : pulse_train_cnt
// Brief  : Loadable down-counter that saturates at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_train_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_train_generator.sv
// ============================================================================
// Module : pulse_train_generator
// Brief  : Generates num pulses of programmable high/low length on trig.
//          Define PULSE_TRAIN_RETRIG_EN to allow restarting a running train.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_train_generator #(
  parameter int LEN_W = pulse_train_pkg::LEN_W_DEF,
  parameter int NUM_W = pulse_train_pkg::NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [NUM_W-1:0] num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  import pulse_train_pkg::*;

`ifdef PULSE_TRAIN_RETRIG_EN
  localparam logic RETRIG = 1'b1;
`else
  localparam logic RETRIG = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [LEN_W-1:0] high_q, high_d;
  logic [LEN_W-1:0] low_q, low_d;
  logic             pulse_q, busy_q, done_q;

  logic             ph_load, ph_en, ph_zero;
  logic [LEN_W-1:0] ph_val;
  logic             pc_load, pc_en, pc_zero;
  logic [NUM_W-1:0] pc_val;
  logic             start;

  assign start = trig && ((state_q == IDLE) || RETRIG);

  // The pulse counter holds pulses remaining after the current one, so a
  // zero count at the end of HIGH means this was the last pulse.
  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    ph_load = 1'b0;
    ph_en   = 1'b0;
    ph_val  = '0;
    pc_load = 1'b0;
    pc_en   = 1'b0;
    pc_val  = '0;
    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      high_d  = high_len;
      low_d   = low_len;
      ph_load = 1'b1;
      ph_val  = (high_len == '0) ? '0 : high_len - LEN_W'(1);
      pc_load = 1'b1;
      pc_val  = (num == '0) ? '0 : num - NUM_W'(1);
      state_d = (num == '0) ? FIN : HIGH;
    end else begin
      case (state_q)
        HIGH: begin
          if (!ph_zero) begin
            ph_en = 1'b1;
          end else if (pc_zero) begin
            state_d = FIN;
          end else begin
            pc_en   = 1'b1;
            ph_load = 1'b1;
            ph_val  = (low_q == '0) ? '0 : low_q - LEN_W'(1);
            state_d = LOW;
          end
        end
        LOW: begin
          if (!ph_zero) begin
            ph_en = 1'b1;
          end else begin
            ph_load = 1'b1;
            ph_val  = (high_q == '0) ? '0 : high_q - LEN_W'(1);
            state_d = HIGH;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      high_q  <= '0;
      low_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      pulse_q <= (state_d == HIGH);
      busy_q  <= (state_d == HIGH) || (state_d == LOW);
      done_q  <= (state_d == FIN);
    end
  end

  pulse_train_cnt #(.W(LEN_W)) u_phase_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .zero     (ph_zero)
  );

  pulse_train_cnt #(.W(NUM_W)) u_pulse_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_val),
    .en       (pc_en),
    .zero     (pc_zero)
  );

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_generator.sv
// ============================================================================
// Module : tb_pulse_train_generator
// Brief  : Directed plus random stimulus against a waveform-schedule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_generator;

`ifdef PULSE_TRAIN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic        abort;
  logic [15:0] high_len;
  logic [15:0] low_len;
  logic [7:0]  num;
  logic        pulse_out;
  logic        busy;
  logic        done;

  int vectors    = 0;
  int miscompares = 0;

  // Expected {pulse_out, busy, done} per cycle, plus the current cycle's value.
  logic [2:0] exp_q[$];
  logic [2:0] cur;

  always #5 clk = ~clk;

  pulse_train_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .trig      (trig),
    .abort     (abort),
    .high_len  (high_len),
    .low_len   (low_len),
    .num       (num),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic build_train(input int h, input int l, input int n);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    exp_q.delete();
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hh; i++) exp_q.push_back(3'b110);
      if (p != n - 1)
        for (int i = 0; i < ll; i++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b001);
  endtask

  task automatic model_edge(input logic t, input logic a, input int h, input int l, input int n);
    if (!rst_n) begin
      exp_q.delete();
    end else if (a) begin
      exp_q.delete();
    end else if (t && ((cur == 3'b000) || RETRIG)) begin
      build_train(h, l, n);
    end
    cur = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
  endtask

  task automatic check(input string tag);
    vectors++;
    assert (pulse_out === cur[2]) else begin
      miscompares++;
      $error("FAIL %s pulse_out observed=%b expected=%b t=%0t", tag, pulse_out, cur[2], $time);
    end
    vectors++;
    assert (busy === cur[1]) else begin
      miscompares++;
      $error("FAIL %s busy observed=%b expected=%b t=%0t", tag, busy, cur[1], $time);
    end
    vectors++;
    assert (done === cur[0]) else begin
      miscompares++;
      $error("FAIL %s done observed=%b expected=%b t=%0t", tag, done, cur[0], $time);
    end
  endtask

  task automatic step(input string tag, input logic t, input logic a,
                      input int h, input int l, input int n);
    trig     = t;
    abort    = a;
    high_len = 16'(h);
    low_len  = 8'(l) == 8'(l) ? 16'(l) : 16'(l);
    num      = 8'(n);
    @(posedge clk);
    model_edge(t, a, h, l, n);
    #1;
    check(tag);
    trig  = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; trig = 1'b0; abort = 1'b0;
    high_len = '0; low_len = '0; num = '0;
    cur = 3'b000;
    #12;
    check("reset");
    rst_n = 1'b1;

    // Trig on the very first edge after reset release: 3/2/3 train
    step("basic_trig", 1'b1, 1'b0, 3, 2, 3);
    idle("basic", 16);

    step("num0_trig", 1'b1, 1'b0, 5, 5, 0);
    idle("num0", 3);

    step("zero_len_trig", 1'b1, 1'b0, 0, 0, 4);
    idle("zero_len", 10);

    // Abort during the second LOW phase (cycles 8-10 for 2/3/5)
    step("abort_trig", 1'b1, 1'b0, 2, 3, 5);
    idle("abort_run", 7);
    step("abort", 1'b0, 1'b1, 0, 0, 0);
    idle("abort_after", 3);
    step("post_abort_trig", 1'b1, 1'b0, 1, 1, 2);
    idle("post_abort", 6);

    // Second trig in cycle 2 with different settings
    step("retrig_first", 1'b1, 1'b0, 3, 2, 2);
    step("retrig_c1", 1'b0, 1'b0, 0, 0, 0);
    step("retrig_second", 1'b1, 1'b0, 2, 1, 3);
    idle("retrig_run", 14);

    // Input wiggle mid-train and abort+trig together
    step("wiggle_trig", 1'b1, 1'b0, 2, 2, 2);
    step("wiggle", 1'b0, 1'b0, 9, 9, 9);
    step("wiggle", 1'b0, 1'b0, 0, 0, 1);
    step("abort_and_trig", 1'b1, 1'b1, 4, 4, 4);
    idle("abort_and_trig_after", 3);

    step("num_max_trig", 1'b1, 1'b0, 0, 0, 255);
    idle("num_max", 512);

    for (int i = 0; i < 800; i++) begin
      step("random",
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 4)),
           int'($urandom_range(0, 4)),
           int'($urandom_range(0, 6)));
    end
    idle("random_drain", 80);

    // Asynchronous reset in the middle of a HIGH phase
    step("rst_mid_trig", 1'b1, 1'b0, 6, 1, 2);
    idle("rst_mid_run", 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    cur = 3'b000;
    check("rst_async");
    idle("rst_held", 2);
    #2;
    rst_n = 1'b1;
    idle("rst_release", 10);
    step("rst_first_trig", 1'b1, 1'b0, 1, 1, 1);
    idle("rst_first", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
